// File: rtl/eth_payload_extractor_pkg.sv
// Shared types and framing constants for the RMII payload extractor.
// The helper maps a destination-address dibit index to its expected wire dibit.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    DROP
  } rx_state_t;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT      = 2'b11;
  localparam int         HEADER_DIBITS  = 56;
  localparam int         FCS_DIBITS     = 16;
  localparam int         MAC_DIBITS     = 24;
  localparam logic [4:0] PRE_CNT_MAX    = 5'd31;

  // Bytes go out MSB-byte first, each byte LSB dibit first.
  function automatic logic [1:0] mac_dibit(input logic [47:0] addr, input logic [5:0] idx);
    int          sh;
    logic [47:0] t;
    sh = 40 - 8 * int'(idx[5:2]) + 2 * int'(idx[1:0]);
    t  = addr >> sh;
    return t[1:0];
  endfunction

endpackage

// File: rtl/eth_payload_extractor_if.sv
// PHY-side receive inputs and payload/status outputs of the extractor.
// slave = extractor side, master = the side driving the PHY dibits.
interface eth_payload_extractor_if #(
  parameter int LEN_W = 16
);
  logic             crsdv;
  logic [1:0]       rxd;
  logic             axiov;
  logic [1:0]       axiod;
  logic             frame_done;
  logic             frame_err;
  logic [LEN_W-1:0] payload_bytes;

  modport master (
    output crsdv, rxd,
    input  axiov, axiod, frame_done, frame_err, payload_bytes
  );

  modport slave (
    input  crsdv, rxd,
    output axiov, axiod, frame_done, frame_err, payload_bytes
  );
endinterface

// File: rtl/eth_payload_extractor_delay.sv
// Fixed-depth dibit shift register with a fill counter; holds back the trailing
// FCS so only payload reaches the output. clear empties it between frames.
module dibit_delay_line #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       shift_en,
  input  logic       clear,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic       full
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]       mem_q [DEPTH];
  logic [CNT_W-1:0] fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'b00;
      fill_q <= '0;
    end else if (clear) begin
      fill_q <= '0;
    end else if (shift_en) begin
      mem_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
      if (!full) fill_q <= fill_q + 1'b1;
    end
  end

  assign dout = mem_q[DEPTH-1];
  assign full = (fill_q == CNT_W'(DEPTH));
endmodule

// File: rtl/eth_payload_extractor.sv
// RMII receive front end: strips preamble/SFD, 14-byte header and FCS, forwards payload dibits.
// Optional destination filter enabled by defining MAC_FILTER_EN.
module eth_payload_extractor
  import eth_rx_pkg::*;
#(
  parameter int          PREAMBLE_MIN = 8,
  parameter logic [47:0] MAC_ADDR     = 48'h0,
  parameter int          LEN_W        = 16
) (
  input logic                    eth_refclk,
  input logic                    rst_n,
  eth_payload_extractor_if.slave bus
);
  localparam int PAY_W = LEN_W + 2;

  rx_state_t        state_q, state_d;
  logic             armed_q, armed_d;
  logic [4:0]       pre_cnt_q, pre_cnt_d;
  logic [5:0]       hdr_cnt_q, hdr_cnt_d;
  logic [PAY_W-1:0] pay_cnt_q, pay_cnt_d;

  logic             axiov_q, axiov_d;
  logic [1:0]       axiod_q, axiod_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] bytes_q, bytes_d;

  logic             dl_shift, dl_clear, dl_full;
  logic [1:0]       dl_dout;

`ifdef MAC_FILTER_EN
  logic mac_ok_q, mac_ok_d, bcast_q, bcast_d;
`else
  logic unused_mac_addr;
  assign unused_mac_addr = ^MAC_ADDR;
`endif

  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      pre_cnt_q <= '0;
      hdr_cnt_q <= '0;
      pay_cnt_q <= '0;
      axiov_q   <= 1'b0;
      axiod_q   <= 2'b00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bytes_q   <= '0;
`ifdef MAC_FILTER_EN
      mac_ok_q  <= 1'b0;
      bcast_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      pre_cnt_q <= pre_cnt_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      axiov_q   <= axiov_d;
      axiod_q   <= axiod_d;
      done_q    <= done_d;
      err_q     <= err_d;
      bytes_q   <= bytes_d;
`ifdef MAC_FILTER_EN
      mac_ok_q  <= mac_ok_d;
      bcast_q   <= bcast_d;
`endif
    end
  end

  // A frame already in flight at reset release is skipped until the line goes idle once.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | ~bus.crsdv;
    pre_cnt_d = pre_cnt_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
`ifdef MAC_FILTER_EN
    mac_ok_d  = mac_ok_q;
    bcast_d   = bcast_q;
`endif
    case (state_q)
      IDLE: begin
        if (armed_q && bus.crsdv && bus.rxd == PREAMBLE_DIBIT) begin
          state_d   = PREAMBLE;
          pre_cnt_d = 5'd1;
        end
      end
      PREAMBLE: begin
        if (!bus.crsdv) begin
          state_d = IDLE;
        end else if (bus.rxd == PREAMBLE_DIBIT) begin
          if (pre_cnt_q != PRE_CNT_MAX) pre_cnt_d = pre_cnt_q + 5'd1;
        end else if (bus.rxd == SFD_DIBIT && int'(pre_cnt_q) >= PREAMBLE_MIN) begin
          state_d   = HEADER;
          hdr_cnt_d = '0;
`ifdef MAC_FILTER_EN
          mac_ok_d  = 1'b1;
          bcast_d   = 1'b1;
`endif
        end else begin
          state_d = DROP;
        end
      end
      HEADER: begin
        if (!bus.crsdv) begin
          state_d = IDLE;
        end else begin
          hdr_cnt_d = hdr_cnt_q + 6'd1;
          if (hdr_cnt_q == 6'(HEADER_DIBITS - 1)) begin
            state_d   = PAYLOAD;
            pay_cnt_d = '0;
          end
`ifdef MAC_FILTER_EN
          if (hdr_cnt_q < 6'(MAC_DIBITS)) begin
            mac_ok_d = mac_ok_q && (bus.rxd == mac_dibit(MAC_ADDR, hdr_cnt_q));
            bcast_d  = bcast_q && (bus.rxd == 2'b11);
            if (hdr_cnt_q == 6'(MAC_DIBITS - 1) && !mac_ok_d && !bcast_d) state_d = DROP;
          end
`endif
        end
      end
      PAYLOAD: begin
        if (!bus.crsdv) state_d = IDLE;
        else if (pay_cnt_q != '1) pay_cnt_d = pay_cnt_q + 1'b1;
      end
      DROP: begin
        if (!bus.crsdv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs; frame status lands the cycle after the envelope drops.
  always_comb begin
    axiov_d = 1'b0;
    axiod_d = axiod_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bytes_d = bytes_q;
    if (state_q == PAYLOAD && bus.crsdv && dl_full) begin
      axiov_d = 1'b1;
      axiod_d = dl_dout;
    end
    if (!bus.crsdv && state_q == HEADER) begin
      done_d  = 1'b1;
      err_d   = 1'b1;
      bytes_d = '0;
    end
    if (!bus.crsdv && state_q == PAYLOAD) begin
      done_d  = 1'b1;
      err_d   = (pay_cnt_q < PAY_W'(FCS_DIBITS)) || (pay_cnt_q[1:0] != 2'b00) || (pay_cnt_q == '1);
      bytes_d = err_d ? '0 : pay_cnt_q[PAY_W-1:2] - LEN_W'(FCS_DIBITS / 4);
    end
  end

  assign dl_shift = (state_q == PAYLOAD) && bus.crsdv;
  assign dl_clear = (state_q != PAYLOAD);

  dibit_delay_line #(.DEPTH(FCS_DIBITS)) u_delay (
    .clk     (eth_refclk),
    .rst_n   (rst_n),
    .shift_en(dl_shift),
    .clear   (dl_clear),
    .din     (bus.rxd),
    .dout    (dl_dout),
    .full    (dl_full)
  );

  assign bus.axiov         = axiov_q;
  assign bus.axiod         = axiod_q;
  assign bus.frame_done    = done_q;
  assign bus.frame_err     = err_q;
  assign bus.payload_bytes = bytes_q;
endmodule
